mac_result_fifo: RTL and testbench
==================================

MAC_RESULT_FIFO -- requirements
Module: mac_result_fifo

Interface
REQ-001 The block SHALL run on one clock; reset SHALL be synchronous and active-high.
REQ-002 Parameter WIDTH, default 24: result word width; it SHALL match the MAC accumulator output.
REQ-003 Parameter DEPTH, default 8: number of FIFO entries; it SHALL be a power of two and at least 2.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 data_in  input  WIDTH signed  accumulator result from part2_mac f.
REQ-007 valid_in  input  1  data_in qualifier, driven from part2_mac valid_out.
REQ-008 data_out  output  WIDTH signed  head-of-queue result.
REQ-009 valid_out  output  1  data_out holds a valid entry.
REQ-010 ready_in  input  1  downstream accepts data_out this cycle.
REQ-011 count  output  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
REQ-012 full  output  1  count == DEPTH.
REQ-013 empty  output  1  count == 0.
REQ-014 drop_err  output  1  sticky flag: at least one input word was discarded.

Function
REQ-015 Write: when valid_in=1 and full=0, data_in SHALL be stored at the write pointer on the rising edge.
REQ-016 Read: when valid_out=1 and ready_in=1, the head entry SHALL be popped on the rising edge.
REQ-017 valid_out SHALL equal !empty; data_out SHALL equal the head entry when valid_out=1 and SHALL be 0 when empty.
REQ-018 Latency: a word written on edge N SHALL appear on data_out and valid_out after edge N if the FIFO was empty; there is no same-cycle bypass.
REQ-019 Order SHALL be strict FIFO; values SHALL pass bit-exact, including -2^(WIDTH-1) and 2^(WIDTH-1)-1.
REQ-020 Read and write in the same cycle while neither empty nor full: both SHALL occur and count SHALL be unchanged.
REQ-021 Full with valid_in=1 and a pop in the same cycle: the write SHALL be accepted, count SHALL stay DEPTH, and drop_err SHALL be unchanged.
REQ-022 Full with valid_in=1 and no pop: data_in SHALL be discarded, drop_err SHALL be set to 1, and contents SHALL be unchanged.
REQ-023 Empty with valid_in=1 and ready_in=1: only the write SHALL occur, because valid_out=0 forbids a pop.
REQ-024 Read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-025 drop_err SHALL remain 1 until reset.
REQ-026 valid_in=0 SHALL cause no write, regardless of data_in.

Reset
REQ-027 While reset=1 at a rising edge, all of the following SHALL be cleared on that edge:
- pointers and count to 0;
- empty to 1; full and valid_out to 0;
- data_out and drop_err to 0.
REQ-028 Reset mid-operation SHALL discard all stored entries. valid_in and ready_in SHALL be ignored in any cycle where reset=1.
REQ-029 Storage array contents need not be cleared; outputs SHALL be masked per REQ-017.

Structure
REQ-030 Shared package mac_pkg SHALL hold:
- constants MAC_IN_W=12, MAC_OUT_W=24, RES_FIFO_DEPTH=8;
- typedef mac_result_t (logic signed [23:0]).
REQ-031 Storage SHALL be one sub-module, mac_fifo_mem:
- DEPTH x WIDTH array;
- registered write port;
- combinational read at the read address.
REQ-032 Pointer, count, flag and drop logic SHALL reside in mac_result_fifo.

Verification
REQ-033 Write 100, -5, 8371389 with ready_in=0 -> count=3, data_out=100; then ready_in=1 -> outputs 100, -5, 8371389 on consecutive cycles, then empty=1, data_out=0.
REQ-034 Write 1..8 with ready_in=0, then write 9 -> full=1, count=8, drop_err=1; drain yields 1..8 only.
REQ-035 Full holding 1..8, write 9 with ready_in=1 in the same cycle -> 1 popped, count=8, drop_err=0; drain yields 2..9.
REQ-036 Stream 20 interleaved writes and reads including -8388608 and 8388607 (pointer wrap twice) -> output order and values match input exactly.
REQ-037 Count=5, then reset=1 with valid_in=1, data_in=7 -> next cycle count=0, empty=1, valid_out=0, drop_err=0, data_out=0.
REQ-038 valid_in=0 while data_in toggles for 10 cycles -> count stays 0, valid_out stays 0.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared MAC constants and the accumulator result type used by the result FIFO.
package mac_pkg;

    localparam int MAC_IN_W       = 12;
    localparam int MAC_OUT_W      = 24;
    localparam int RES_FIFO_DEPTH = 8;

    typedef logic signed [MAC_OUT_W-1:0] mac_result_t;

endpackage

// File: rtl/mac_result_fifo_if.sv
// Handshake bundle between the MAC result producer/consumer and the result FIFO.
interface mac_result_fifo_if
    import mac_pkg::*;
#(
    parameter int WIDTH = MAC_OUT_W,
    parameter int DEPTH = RES_FIFO_DEPTH
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic signed [WIDTH-1:0] data_in;
    logic                    valid_in;
    logic signed [WIDTH-1:0] data_out;
    logic                    valid_out;
    logic                    ready_in;
    logic [CW-1:0]           count;
    logic                    full;
    logic                    empty;
    logic                    drop_err;

    modport master (
        output data_in, valid_in, ready_in,
        input  data_out, valid_out, count, full, empty, drop_err
    );

    modport slave (
        input  data_in, valid_in, ready_in,
        output data_out, valid_out, count, full, empty, drop_err
    );
endinterface

// File: rtl/mac_fifo_mem.sv
// FIFO storage: DEPTH x WIDTH array, clocked write port, combinational read port.
module mac_fifo_mem
    import mac_pkg::*;
#(
    parameter int WIDTH = MAC_OUT_W,
    parameter int DEPTH = RES_FIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    // Contents are never cleared; the controller masks data_out while empty.
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/mac_result_fifo.sv
// Result FIFO behind the MAC: pointers, occupancy, status flags and sticky drop detection.
module mac_result_fifo
    import mac_pkg::*;
#(
    parameter int WIDTH = MAC_OUT_W,
    parameter int DEPTH = RES_FIFO_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    mac_result_fifo_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             drop_err_q, drop_err_d;
    logic             push, pop, full, empty;
    logic [WIDTH-1:0] rdata;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    always_comb begin
        pop        = !empty && bus.ready_in;
        // A pop in the same cycle frees a slot, so a full FIFO still accepts.
        push       = bus.valid_in && (!full || pop);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        drop_err_d = drop_err_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (bus.valid_in && !push) begin
            drop_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_err_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drop_err_q <= drop_err_d;
        end
    end

    mac_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (push && !reset),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.data_in),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );

    assign bus.data_out  = empty ? '0 : rdata;
    assign bus.valid_out = !empty;
    assign bus.count     = count_q;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.drop_err  = drop_err_q;
endmodule

// File: tb/tb_mac_result_fifo.sv
// Self-checking bench for mac_result_fifo against a queue-based reference model.
module tb_mac_result_fifo;
    import mac_pkg::*;

    localparam int W = MAC_OUT_W;
    localparam int D = RES_FIFO_DEPTH;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mac_result_fifo_if #(.WIDTH(W), .DEPTH(D)) bus ();

    mac_result_fifo #(.WIDTH(W), .DEPTH(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          errors = 0;
    int          checks = 0;
    mac_result_t model_q[$];
    bit          drop_m = 1'b0;

    // One clock with the given inputs; the model advances from its pre-edge state.
    task automatic drive(input bit v, input mac_result_t d, input bit r);
        bit pop_m;
        bit full_m;
        bus.valid_in = v;
        bus.data_in  = d;
        bus.ready_in = r;
        full_m = (model_q.size() == D);
        pop_m  = (model_q.size() != 0) && r;
        if (pop_m) void'(model_q.pop_front());
        if (v) begin
            if (!full_m || pop_m) model_q.push_back(d);
            else                  drop_m = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.valid_in = 1'($urandom);
        bus.ready_in = 1'($urandom);
        bus.data_in  = mac_result_t'($urandom);
        @(posedge clk);
        #1;
        reset        = 1'b0;
        bus.valid_in = 1'b0;
        bus.ready_in = 1'b0;
        model_q.delete();
        drop_m = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.count !== '0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        checks++;
        if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.valid_out !== 1'b0) begin
            errors++; $display("FAIL reset_flags got empty=%b full=%b valid=%b exp 1 0 0", bus.empty, bus.full, bus.valid_out);
        end
        checks++;
        if (bus.data_out !== '0 || bus.drop_err !== 1'b0) begin
            errors++; $display("FAIL reset_data got data=%0d drop=%b exp 0 0", bus.data_out, bus.drop_err);
        end
    endtask

    task automatic test_hold_then_drain();
        mac_result_t exp_v[3];
        exp_v[0] = 100; exp_v[1] = -5; exp_v[2] = 8371389;
        do_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, exp_v[i], 1'b0);
        bus.valid_in = 1'b0;
        checks++;
        if (bus.count !== 4'd3 || bus.data_out !== exp_v[0]) begin
            errors++; $display("FAIL hold_state got count=%0d data=%0d exp 3 100", bus.count, bus.data_out);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.valid_out !== 1'b1 || bus.data_out !== exp_v[i]) begin
                errors++; $display("FAIL drain_%0d got valid=%b data=%0d exp 1 %0d", i, bus.valid_out, bus.data_out, exp_v[i]);
            end
            drive(1'b0, '0, 1'b1);
        end
        checks++;
        if (bus.empty !== 1'b1 || bus.data_out !== '0) begin
            errors++; $display("FAIL drain_empty got empty=%b data=%0d exp 1 0", bus.empty, bus.data_out);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 9; i++) drive(1'b1, mac_result_t'(i), 1'b0);
        bus.valid_in = 1'b0;
        checks++;
        if (bus.full !== 1'b1 || bus.count !== 4'd8 || bus.drop_err !== 1'b1) begin
            errors++; $display("FAIL overflow got full=%b count=%0d drop=%b exp 1 8 1", bus.full, bus.count, bus.drop_err);
        end
        for (int i = 1; i <= 8; i++) begin
            checks++;
            if (bus.data_out !== mac_result_t'(i)) begin
                errors++; $display("FAIL overflow_drain got=%0d exp=%0d", bus.data_out, i);
            end
            drive(1'b0, '0, 1'b1);
        end
        checks++;
        if (bus.empty !== 1'b1 || bus.drop_err !== 1'b1) begin
            errors++; $display("FAIL overflow_end got empty=%b drop=%b exp 1 1", bus.empty, bus.drop_err);
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 1; i <= 8; i++) drive(1'b1, mac_result_t'(i), 1'b0);
        drive(1'b1, mac_result_t'(9), 1'b1);
        bus.valid_in = 1'b0;
        checks++;
        if (bus.count !== 4'd8 || bus.drop_err !== 1'b0 || bus.data_out !== mac_result_t'(2)) begin
            errors++; $display("FAIL full_push_pop got count=%0d drop=%b head=%0d exp 8 0 2", bus.count, bus.drop_err, bus.data_out);
        end
        for (int i = 2; i <= 9; i++) begin
            checks++;
            if (bus.data_out !== mac_result_t'(i)) begin
                errors++; $display("FAIL full_push_pop_drain got=%0d exp=%0d", bus.data_out, i);
            end
            drive(1'b0, '0, 1'b1);
        end
    endtask

    task automatic test_stream_wrap();
        mac_result_t vals[20];
        int tx = 0;
        int rx = 0;
        bit v, r;
        for (int i = 0; i < 20; i++) vals[i] = mac_result_t'($urandom);
        vals[3]  = -24'sd8388608;
        vals[11] = 24'sd8388607;
        do_reset();
        for (int cyc = 0; cyc < 400 && rx < 20; cyc++) begin
            r = 1'($urandom);
            v = (tx < 20) && (model_q.size() < D) && ($urandom_range(0, 3) != 0);
            if (bus.valid_out && r) begin
                checks++;
                if (bus.data_out !== vals[rx]) begin
                    errors++; $display("FAIL stream_%0d got=%0d exp=%0d", rx, bus.data_out, vals[rx]);
                end else begin
                    $display("stream pop %0d value=%0d", rx, bus.data_out);
                end
                rx++;
            end
            drive(v, v ? vals[tx] : mac_result_t'($urandom), r);
            if (v) tx++;
            checks++;
            if (int'(bus.count) !== model_q.size()) begin
                errors++; $display("FAIL stream_count got=%0d exp=%0d", bus.count, model_q.size());
            end
        end
        checks++;
        if (rx != 20) begin errors++; $display("FAIL stream_timeout got=%0d exp=20 words", rx); end
    endtask

    task automatic test_midop_reset();
        do_reset();
        for (int i = 1; i <= 9; i++) drive(1'b1, mac_result_t'(i * 3), 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1);
        checks++;
        if (bus.count !== 4'd5 || bus.drop_err !== 1'b1) begin
            errors++; $display("FAIL midop_pre got count=%0d drop=%b exp 5 1", bus.count, bus.drop_err);
        end
        reset = 1'b1; bus.valid_in = 1'b1; bus.data_in = 7; bus.ready_in = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0; bus.valid_in = 1'b0; bus.ready_in = 1'b0;
        model_q.delete(); drop_m = 1'b0;
        checks++;
        if (bus.count !== '0 || bus.empty !== 1'b1 || bus.valid_out !== 1'b0 || bus.drop_err !== 1'b0 || bus.data_out !== '0) begin
            errors++; $display("FAIL midop_reset got count=%0d empty=%b valid=%b drop=%b data=%0d exp 0 1 0 0 0",
                               bus.count, bus.empty, bus.valid_out, bus.drop_err, bus.data_out);
        end
    endtask

    task automatic test_valid_low();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, mac_result_t'($urandom), 1'($urandom));
            checks++;
            if (bus.count !== '0 || bus.valid_out !== 1'b0) begin
                errors++; $display("FAIL valid_low_%0d got count=%0d valid=%b exp 0 0", i, bus.count, bus.valid_out);
            end
        end
    endtask

    task automatic test_random();
        mac_result_t exp_d;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 9) < 6), mac_result_t'($urandom), 1'($urandom_range(0, 9) < 4));
            exp_d = (model_q.size() != 0) ? model_q[0] : '0;
            checks++;
            if (int'(bus.count) !== model_q.size() || bus.data_out !== exp_d || bus.drop_err !== drop_m
                || bus.full !== (model_q.size() == D) || bus.valid_out !== (model_q.size() != 0)) begin
                errors++; $display("FAIL random_%0d got count=%0d data=%0d drop=%b full=%b valid=%b exp %0d %0d %b",
                                   i, bus.count, bus.data_out, bus.drop_err, bus.full, bus.valid_out,
                                   model_q.size(), exp_d, drop_m);
            end
        end
    endtask

    initial begin
        reset        = 1'b0;
        bus.valid_in = 1'b0;
        bus.ready_in = 1'b0;
        bus.data_in  = '0;
        test_reset();
        test_hold_then_drain();
        test_overflow();
        test_full_push_pop();
        test_stream_wrap();
        test_midop_reset();
        test_valid_low();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
